// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Issues sequential word fetches to instruction
// memory over a req/ack handshake, buffers the returned words in a DEPTH-entry
// prefetch FIFO and hands them to decode over a valid/ready interface.
// Redirects (branches/jumps) flush the FIFO and discard any response that is
// still in flight for the old path. An access fault is delivered as a tagged
// entry and stops further fetching until the next redirect.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   inst_re        fetch request (registered)
//   inst_addr      fetch address (registered, word aligned)
//   inst_ack       memory response valid this cycle
//   inst_err       access fault, qualified by inst_ack
//   inst           fetched word, qualified by inst_ack
//   redirect       flush the buffer and restart fetch at redirect_addr
//   redirect_addr  new fetch PC, bits [1:0] are treated as zero
//   fe_valid       FIFO head valid
//   fe_ready       decode accepts the head this cycle
//   fe_inst        head instruction word
//   fe_pc          head PC
//   fe_err         head carries an access fault
//
// DEPTH must be a power of two and at least 2 so the FIFO pointers wrap
// naturally at their bit width.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,

    output logic            inst_re,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_ack,
    input  logic            inst_err,
    input  logic [31:0]     inst,

    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_addr,

    output logic            fe_valid,
    input  logic            fe_ready,
    output logic [31:0]     fe_inst,
    output logic [XLEN-1:0] fe_pc,
    output logic            fe_err
);

    localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Force a fetch address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    // Next sequential word address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] a);
        return a + XLEN'(4);
    endfunction

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  r_inst_addr;
    logic             r_req;
    logic             r_discard;
    logic             r_halt;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;

    // FIFO storage (data only, not reset)
    logic [31:0]      r_fifo_inst [DEPTH];
    logic [XLEN-1:0]  r_fifo_pc   [DEPTH];
    logic             r_fifo_err  [DEPTH];

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic             w_accept;
    logic             w_hold;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_next;
    logic             w_halt_next;
    logic             w_discard_next;
    logic [XLEN-1:0]  w_fetch_pc_next;
    logic             w_req_next;
    logic [XLEN-1:0]  w_addr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [PTR_W-1:0] w_wr_ptr_next;

    // A response counts only while our request is up; a stray ack is ignored.
    assign w_accept = r_req & inst_ack;
    // Request is up and memory has not answered yet: it must stay stable.
    assign w_hold   = r_req & ~inst_ack;
    // A redirect in the same cycle wins over both push and pop, and a
    // response belonging to a flushed path is never stored.
    assign w_push   = w_accept & ~r_discard & ~redirect;
    assign w_pop    = (r_count != '0) & fe_ready & ~redirect;

    always_comb begin
        w_count_next    = r_count;
        w_halt_next     = r_halt;
        w_discard_next  = r_discard;
        w_fetch_pc_next = r_fetch_pc;
        w_rd_ptr_next   = r_rd_ptr;
        w_wr_ptr_next   = r_wr_ptr;

        if (redirect) begin
            w_count_next    = '0;
            w_halt_next     = 1'b0;
            w_fetch_pc_next = align_word(redirect_addr);
            w_rd_ptr_next   = '0;
            w_wr_ptr_next   = '0;
            // The held request will still be answered by memory; remember to
            // drop that answer. An answer arriving right now is dropped here.
            w_discard_next  = w_hold;
        end else begin
            if (w_accept) begin
                w_discard_next = 1'b0;
            end
            if (w_push) begin
                w_fetch_pc_next = next_word(r_fetch_pc);
                w_wr_ptr_next   = r_wr_ptr + PTR_W'(1);
                if (inst_err) begin
                    w_halt_next = 1'b1;
                end
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                w_count_next = r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                w_count_next = r_count - CNT_W'(1);
            end
        end

        // A request that is still waiting keeps its address untouched; a new
        // one is only raised when there is space for its answer. Because the
        // count can only grow on an ack, a held request never meets a full
        // FIFO.
        if (w_hold) begin
            w_req_next  = 1'b1;
            w_addr_next = r_inst_addr;
        end else begin
            w_req_next  = !w_halt_next && (w_count_next < CNT_FULL);
            w_addr_next = w_fetch_pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_ADDR;
            r_inst_addr <= RESET_ADDR;
            r_req       <= 1'b0;
            r_discard   <= 1'b0;
            r_halt      <= 1'b0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
        end else begin
            r_fetch_pc  <= w_fetch_pc_next;
            r_inst_addr <= w_addr_next;
            r_req       <= w_req_next;
            r_discard   <= w_discard_next;
            r_halt      <= w_halt_next;
            r_count     <= w_count_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_wr_ptr    <= w_wr_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_fifo_inst[r_wr_ptr] <= inst;
            r_fifo_pc[r_wr_ptr]   <= r_inst_addr;
            r_fifo_err[r_wr_ptr]  <= inst_err;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign inst_re   = r_req;
    assign inst_addr = r_inst_addr;

    // The head is read straight from storage: an entry written at an edge is
    // first visible after that edge, so there is no same-cycle bypass.
    assign fe_valid  = (r_count != '0);
    assign fe_inst   = r_fifo_inst[r_rd_ptr];
    assign fe_pc     = r_fifo_pc[r_rd_ptr];
    assign fe_err    = r_fifo_err[r_rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. The bench plays instruction memory and decode. A
// reference model tracks, in plain terms, the PC the next live response must
// belong to, whether the outstanding response is stale, whether fetch is halted
// after a fault, and the queue of entries decode should see. A monitor process
// compares every cycle's FIFO head against the front of that queue.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          XLEN       = 32;
    localparam int          DEPTH      = 4;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_re;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic        inst_err;
    logic [31:0] inst;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        fe_valid;
    logic        fe_ready;
    logic [31:0] fe_inst;
    logic [31:0] fe_pc;
    logic        fe_err;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (XLEN),
        .DEPTH      (DEPTH),
        .RESET_ADDR (RESET_ADDR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_re       (inst_re),
        .inst_addr     (inst_addr),
        .inst_ack      (inst_ack),
        .inst_err      (inst_err),
        .inst          (inst),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fe_valid      (fe_valid),
        .fe_ready      (fe_ready),
        .fe_inst       (fe_inst),
        .fe_pc         (fe_pc),
        .fe_err        (fe_err)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } ent_t;

    ent_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference model state
    logic [31:0] m_pc        = RESET_ADDR;
    logic [31:0] m_prev_addr = '0;
    bit          m_halted    = 1'b0;
    bit          m_stale     = 1'b0;
    bit          m_held      = 1'b0;
    bit          m_prev_rst  = 1'b0;
    bit          started     = 1'b0;
    logic [31:0] salt        = '0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode-side monitor: mid-cycle, compare the visible head with the model.
    task automatic monitor();
        ent_t e;
        forever begin
            @(negedge clk);
            if (started && rst === 1'b0) begin
                chk32("fe_valid", {31'b0, fe_valid}, {31'b0, (exp_q.size() != 0)});
                if (fe_valid === 1'b1 && exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk32("fe_pc",   fe_pc,             e.pc);
                    chk32("fe_inst", fe_inst,           e.inst);
                    chk32("fe_err",  {31'b0, fe_err},   {31'b0, e.err});
                    if (fe_ready === 1'b1 && redirect === 1'b0) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    // One clock cycle: check the request side, drive inputs, then update the
    // model with what the edge must have done. Entered and left 2 time units
    // after a rising edge.
    task automatic cyc(input bit a_rst, input bit a_ack, input bit a_err,
                       input bit a_rdy, input bit a_redir, input logic [31:0] a_raddr);
        bit          exp_re;
        bit          re_s;
        logic [31:0] addr_s;
        logic [31:0] data;
        if (started) begin
            if (m_prev_rst)  exp_re = 1'b0;
            else if (m_held) exp_re = 1'b1;
            else             exp_re = !m_halted && (exp_q.size() < DEPTH);
            chk32("inst_re", {31'b0, inst_re}, {31'b0, exp_re});
            if (inst_re === 1'b1) begin
                chk32("inst_addr", inst_addr, m_held ? m_prev_addr : m_pc);
            end
        end
        re_s   = (inst_re === 1'b1);
        addr_s = inst_addr;
        data   = inst_addr ^ salt;

        rst           = a_rst;
        inst_ack      = a_ack;
        inst_err      = a_err;
        inst          = data;
        fe_ready      = a_rdy;
        redirect      = a_redir;
        redirect_addr = a_raddr;

        @(posedge clk);
        #1;
        if (a_rst) begin
            exp_q.delete();
            m_pc       = RESET_ADDR;
            m_halted   = 1'b0;
            m_stale    = 1'b0;
            m_held     = 1'b0;
            m_prev_rst = 1'b1;
            started    = 1'b1;
        end else begin
            m_prev_rst = 1'b0;
            if (a_redir) begin
                exp_q.delete();
                m_halted = 1'b0;
                m_pc     = {a_raddr[31:2], 2'b00};
                m_stale  = re_s && !a_ack;
            end else if (re_s && a_ack) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    exp_q.push_back('{inst: data, pc: m_pc, err: a_err});
                    m_pc = m_pc + 32'd4;
                    if (a_err) m_halted = 1'b1;
                end
            end
            m_held      = re_s && !a_ack;
            m_prev_addr = addr_s;
        end
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    // Zero-wait memory, decode always ready.
    task automatic stream(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        inst_ack      = 1'b0;
        inst_err      = 1'b0;
        inst          = '0;
        fe_ready      = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        fork
            monitor();
        join_none
        #2;

        // Reset state
        do_reset();
        chk32("reset_inst_re",  {31'b0, inst_re},  32'd0);
        chk32("reset_fe_valid", {31'b0, fe_valid}, 32'd0);

        // Back-to-back zero-wait stream
        stream(12);

        // Fill with decode stalled, then drain
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk32("full_inst_re",  {31'b0, inst_re},  32'd0);
        chk32("full_fe_valid", {31'b0, fe_valid}, 32'd1);
        chk32("full_head_pc",  fe_pc,             32'h0);
        stream(1);
        chk32("drain_inst_re",   {31'b0, inst_re}, 32'd1);
        chk32("drain_inst_addr", inst_addr,        32'h10);
        stream(9);

        // Slow response on 0x8 with a redirect while it waits
        do_reset();
        stream(3);
        chk32("wait_addr", inst_addr, 32'h8);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        chk32("held_addr", inst_addr, 32'h8);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk32("after_discard_addr", inst_addr, 32'h100);
        stream(1);
        chk32("after_discard_pc", fe_pc, 32'h100);
        stream(4);

        // Redirect coinciding with an ack and a pop
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200);
        chk32("same_cycle_valid", {31'b0, fe_valid}, 32'd0);
        chk32("same_cycle_addr",  inst_addr,         32'h200);
        stream(4);

        // Access fault on 0x10
        do_reset();
        stream(5);
        chk32("fault_addr", inst_addr, 32'h10);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk32("fault_pc",  fe_pc,            32'h10);
        chk32("fault_err", {31'b0, fe_err},  32'd1);
        stream(3);
        chk32("halt_inst_re", {31'b0, inst_re}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
        chk32("resume_addr", inst_addr, 32'h40);
        stream(4);

        // Address wrap
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        chk32("wrap_addr_hi", inst_addr, 32'hFFFF_FFFC);
        stream(1);
        chk32("wrap_addr_lo", inst_addr, 32'h0);
        stream(3);

        // Reset while a request is held
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk32("held_before_rst", {31'b0, inst_re}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk32("rst_mid_inst_re",  {31'b0, inst_re},  32'd0);
        chk32("rst_mid_fe_valid", {31'b0, fe_valid}, 32'd0);
        stream(1);
        chk32("restart_re",   {31'b0, inst_re}, 32'd1);
        chk32("restart_addr", inst_addr,        RESET_ADDR);
        stream(3);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst, r_ack, r_err, r_rdy, r_redir;
            logic [31:0] r_addr;
            salt    = $urandom;
            r_rst   = ($urandom_range(0, 399) == 0);
            r_ack   = ($urandom_range(0, 3) != 0);
            r_err   = ($urandom_range(0, 31) == 0);
            r_rdy   = ($urandom_range(0, 2) != 0);
            r_redir = ($urandom_range(0, 19) == 0);
            r_addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
            cyc(r_rst, r_ack, r_err, r_rdy, r_redir, r_addr);
        end

        // Quiet tail so the last entries drain through the monitor
        salt = '0;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
